// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btn_pkg
// Description : Shared constants for the push-button debouncer. The default
//               debounce window comes from the system clock rate and the
//               desired settle time.
// Revision    : 1.0 - initial release
// ============================================================================
package btn_pkg;

  localparam int unsigned CLK_HZ      = 27_000_000;
  localparam int unsigned DEBOUNCE_MS = 10;

  // 10 ms at 27 MHz = 270000 cycles
  localparam int unsigned DEF_STABLE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;

  // Counter width that can hold every value 0..cycles without wrapping
  function automatic int cnt_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce_ch.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce_ch
// Description : One debounced button channel: 2-flop synchronizer, stability
//               counter, clean-level register and press/release pulses.
//               Pins are active-low, so a press is a 1->0 transition.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic clean_o,
  output logic press_o,
  output logic release_o
);

  localparam int                CW       = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0]     CNT_LAST = CW'(STABLE_CYCLES - 1);

  // A window shorter than two cycles cannot be told apart from the
  // synchronizer delay, so refuse to build it.
  if (STABLE_CYCLES < 2) begin : g_param_check
    $error("btn_debounce_ch: STABLE_CYCLES must be at least 2");
  end

  logic          s1_q;
  logic          s2_q;
  logic [CW-1:0] cnt_q,     cnt_d;
  logic          clean_q,   clean_d;
  logic          press_q,   press_d;
  logic          release_q, release_d;

  // Next state: count consecutive cycles the synchronized pin disagrees with
  // the clean level; accept the new level on the last one of the window.
  always_comb begin
    cnt_d     = '0;
    clean_d   = clean_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (s2_q != clean_q) begin
      if (cnt_q == CNT_LAST) begin
        clean_d   = s2_q;
        press_d   = ~s2_q;
        release_d = s2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // State registers; reset parks the channel in the released state.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= 1'b1;
      s2_q      <= 1'b1;
      cnt_q     <= '0;
      clean_q   <= 1'b1;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      s1_q      <= btn_i;
      s2_q      <= s1_q;
      cnt_q     <= cnt_d;
      clean_q   <= clean_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign clean_o   = clean_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Multi-channel push-button debouncer. Each active-low pin gets
//               its own independent debounce channel.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned NUM_BTN       = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn,
  output logic [NUM_BTN-1:0] btn_clean,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);

  // One channel per pin; bit 0 is btn1, bit 1 is btn2.
  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    btn_debounce_ch #(
      .STABLE_CYCLES (STABLE_CYCLES)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .btn_i     (btn[g]),
      .clean_o   (btn_clean[g]),
      .press_o   (btn_press[g]),
      .release_o (btn_release[g])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_btn_debounce
// Description : Self-checking bench for btn_debounce with a 4-cycle window.
//               Latencies are counted in clock edges with the edge that first
//               samples the new pin level numbered 1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_debounce;

  localparam int S = 4;
  localparam int N = 2;

  logic         clk;
  logic         rst;
  logic [N-1:0] btn;
  logic [N-1:0] btn_clean;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;

  int n_cmp;
  int n_bad;

  btn_debounce #(
    .STABLE_CYCLES (S),
    .NUM_BTN       (N)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn         (btn),
    .btn_clean   (btn_clean),
    .btn_press   (btn_press),
    .btn_release (btn_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a level is accepted once the last S synchronized
  // samples all disagree with the current clean level.
  logic [N-1:0] m_s1, m_s2, exp_clean, exp_press, exp_rel;
  logic [S-1:0] m_win [N];
  logic [S-1:0] w_win [N];
  logic [N-1:0] w_flip;

  always_comb begin
    for (int c = 0; c < N; c++) begin
      w_win[c]  = {m_win[c][S-2:0], m_s2[c]};
      w_flip[c] = (w_win[c] == {S{~exp_clean[c]}});
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      m_s1      <= '1;
      m_s2      <= '1;
      exp_clean <= '1;
      exp_press <= '0;
      exp_rel   <= '0;
      for (int c = 0; c < N; c++) m_win[c] <= '1;
    end else begin
      m_s1 <= btn;
      m_s2 <= m_s1;
      for (int c = 0; c < N; c++) begin
        m_win[c]     <= w_win[c];
        exp_clean[c] <= w_flip[c] ? ~exp_clean[c] : exp_clean[c];
        exp_press[c] <= w_flip[c] & exp_clean[c];
        exp_rel[c]   <= w_flip[c] & ~exp_clean[c];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn = N'($urandom_range(0, 3));
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (btn_clean !== 2'b11) begin
        n_bad++;
        $display("FAIL reset_clean: got %b want 11", btn_clean);
      end
      n_cmp++;
      if (btn_press !== 2'b00) begin
        n_bad++;
        $display("FAIL reset_press: got %b want 00", btn_press);
      end
      n_cmp++;
      if (btn_release !== 2'b00) begin
        n_bad++;
        $display("FAIL reset_release: got %b want 00", btn_release);
      end
    end
    btn = 2'b11;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_idle();
    int bad_cycles;
    bad_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (btn_clean !== 2'b11 || btn_press !== 2'b00 || btn_release !== 2'b00)
        bad_cycles++;
    end
    n_cmp++;
    if (bad_cycles != 0) begin
      n_bad++;
      $display("FAIL idle: %0d cycles off, want 0 (last clean=%b press=%b rel=%b)",
               bad_cycles, btn_clean, btn_press, btn_release);
    end
  endtask

  task automatic test_press_latency();
    int fall_k, press_k, press_cnt, rel_cnt;
    bit ch1_moved;
    fall_k = 0; press_k = 0; press_cnt = 0; rel_cnt = 0; ch1_moved = 0;
    btn = 2'b10;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (btn_clean[0] === 1'b0 && fall_k == 0) fall_k = k;
      if (btn_press[0] === 1'b1) begin
        press_cnt++;
        press_k = k;
      end
      if (btn_release !== 2'b00) rel_cnt++;
      if (btn_clean[1] !== 1'b1 || btn_press[1] !== 1'b0) ch1_moved = 1;
    end
    n_cmp++;
    if (fall_k != S + 2) begin
      n_bad++;
      $display("FAIL press_latency: clean fell at edge %0d want %0d", fall_k, S + 2);
    end
    n_cmp++;
    if (press_cnt != 1 || press_k != S + 2) begin
      n_bad++;
      $display("FAIL press_pulse: %0d pulses at edge %0d want 1 at %0d",
               press_cnt, press_k, S + 2);
    end
    n_cmp++;
    if (ch1_moved || rel_cnt != 0) begin
      n_bad++;
      $display("FAIL press_isolation: ch1_moved=%0d releases=%0d want 0/0",
               ch1_moved, rel_cnt);
    end
    btn = 2'b11;
    rel_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (btn_release[0] === 1'b1) rel_cnt++;
    end
    n_cmp++;
    if (btn_clean !== 2'b11 || rel_cnt != 1) begin
      n_bad++;
      $display("FAIL release_after_press: clean=%b releases=%0d want 11/1",
               btn_clean, rel_cnt);
    end
  endtask

  task automatic test_glitch();
    int pulses;
    bit moved;
    pulses = 0; moved = 0;
    btn = 2'b10;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (btn_clean !== 2'b11) moved = 1;
      if (btn_press !== 2'b00 || btn_release !== 2'b00) pulses++;
    end
    btn = 2'b11;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (btn_clean !== 2'b11) moved = 1;
      if (btn_press !== 2'b00 || btn_release !== 2'b00) pulses++;
    end
    n_cmp++;
    if (moved || pulses != 0) begin
      n_bad++;
      $display("FAIL glitch: clean_moved=%0d pulse_cycles=%0d want 0/0", moved, pulses);
    end
  endtask

  task automatic test_bounce();
    bit pat [0:8];
    int t, press_t, press_cnt;
    bit ch0_moved;
    pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    t = 0; press_t = 0; press_cnt = 0; ch0_moved = 0;
    for (int i = 0; i < 9; i++) begin
      btn = {pat[i], 1'b1};
      tick();
      t++;
      if (btn_press[1] === 1'b1) begin press_cnt++; press_t = t; end
      if (btn_clean[0] !== 1'b1) ch0_moved = 1;
    end
    while (t < 25) begin
      tick();
      t++;
      if (btn_press[1] === 1'b1) begin press_cnt++; press_t = t; end
      if (btn_clean[0] !== 1'b1) ch0_moved = 1;
    end
    // Last 1->0 sample (pattern index 5) is taken on edge 6.
    n_cmp++;
    if (press_cnt != 1 || press_t != 6 + S + 1) begin
      n_bad++;
      $display("FAIL bounce_press: %0d pulses, last at edge %0d want 1 at %0d",
               press_cnt, press_t, 6 + S + 1);
    end
    n_cmp++;
    if (btn_clean !== 2'b01 || ch0_moved) begin
      n_bad++;
      $display("FAIL bounce_clean: clean=%b ch0_moved=%0d want 01/0", btn_clean, ch0_moved);
    end
    btn = 2'b11;
    for (int k = 0; k < 12; k++) tick();
  endtask

  task automatic test_simultaneous();
    int both, partial, both_k;
    both = 0; partial = 0; both_k = 0;
    btn = 2'b00;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (btn_press === 2'b11) begin both++; both_k = k; end
      else if (btn_press !== 2'b00) partial++;
    end
    n_cmp++;
    if (both != 1 || partial != 0 || both_k != S + 2) begin
      n_bad++;
      $display("FAIL simul_press: joint=%0d split=%0d edge=%0d want 1/0/%0d",
               both, partial, both_k, S + 2);
    end
    both = 0; partial = 0; both_k = 0;
    btn = 2'b11;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (btn_release === 2'b11) begin both++; both_k = k; end
      else if (btn_release !== 2'b00) partial++;
    end
    n_cmp++;
    if (both != 1 || partial != 0 || both_k != S + 2) begin
      n_bad++;
      $display("FAIL simul_release: joint=%0d split=%0d edge=%0d want 1/0/%0d",
               both, partial, both_k, S + 2);
    end
  endtask

  task automatic test_reset_midcount();
    int press_k, press_cnt;
    press_k = 0; press_cnt = 0;
    btn = 2'b10;
    // Four edges: two synchronizer stages, then count reaches 2.
    for (int k = 0; k < 4; k++) tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    n_cmp++;
    if (btn_clean !== 2'b11 || btn_press !== 2'b00 || btn_release !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_mid_first: clean=%b press=%b rel=%b want 11/00/00",
               btn_clean, btn_press, btn_release);
    end
    if (btn_press[0] === 1'b1) begin press_cnt++; press_k = 1; end
    for (int k = 2; k <= 16; k++) begin
      tick();
      if (btn_press[0] === 1'b1) begin press_cnt++; press_k = k; end
    end
    n_cmp++;
    if (press_cnt != 1 || press_k != S + 2) begin
      n_bad++;
      $display("FAIL reset_mid_press: %0d pulses at edge %0d want 1 at %0d",
               press_cnt, press_k, S + 2);
    end
    btn = 2'b11;
    for (int k = 0; k < 12; k++) tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 5) == 0) btn[c] = ~btn[c];
      rst = ($urandom_range(0, 199) == 0);
      tick();
      n_cmp++;
      if (btn_clean !== exp_clean) begin
        n_bad++;
        $display("FAIL rand_clean @%0d: got %b want %b", i, btn_clean, exp_clean);
      end
      n_cmp++;
      if (btn_press !== exp_press) begin
        n_bad++;
        $display("FAIL rand_press @%0d: got %b want %b", i, btn_press, exp_press);
      end
      n_cmp++;
      if (btn_release !== exp_rel) begin
        n_bad++;
        $display("FAIL rand_release @%0d: got %b want %b", i, btn_release, exp_rel);
      end
      n_cmp++;
      if ((btn_press & btn_release) !== 2'b00) begin
        n_bad++;
        $display("FAIL rand_exclusive @%0d: press&release=%b want 00", i,
                 btn_press & btn_release);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    btn   = 2'b11;
    test_reset();
    test_idle();
    test_press_latency();
    test_glitch();
    test_bounce();
    test_simultaneous();
    test_reset_midcount();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 270000 (10 ms at 27 MHz), meaning consecutive synchronized cycles a new pin level must hold before it is accepted.
REQ-002 SHALL have parameter NUM_BTN, default 2, meaning the number of independent button channels.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all state SHALL be updated on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port btn, input, NUM_BTN bits: raw asynchronous pins, active-low; bit 0 is btn1 and bit 1 is btn2.
REQ-006 SHALL have port btn_clean, output, NUM_BTN bits: debounced level, with the same polarity as the pins.
REQ-007 SHALL have port btn_press, output, NUM_BTN bits: one-cycle pulse on each debounced 1->0 transition.
REQ-008 SHALL have port btn_release, output, NUM_BTN bits: one-cycle pulse on each debounced 0->1 transition.

Function
REQ-009 Each channel SHALL pass its pin through a 2-flop synchronizer (s1, s2) before any other use.
REQ-010 Each channel SHALL hold a counter of width $clog2(STABLE_CYCLES+1) bits that never wraps.
REQ-011 Per cycle, if s2 equals btn_clean, the counter SHALL clear to 0.
REQ-012 Per cycle, if s2 differs from btn_clean and the counter is below STABLE_CYCLES-1, the counter SHALL increment by 1.
REQ-013 Per cycle, if s2 differs from btn_clean and the counter equals STABLE_CYCLES-1, btn_clean SHALL take the value of s2 and the counter SHALL clear to 0.
REQ-014 btn_press or btn_release SHALL be registered alongside btn_clean: high for exactly the first cycle that btn_clean shows its new value, low at all other times.
REQ-015 Latency: a pin change held stable SHALL appear on btn_clean exactly STABLE_CYCLES+2 clocks after the first clock edge that samples the new pin value.
REQ-016 A pin glitch lasting fewer than STABLE_CYCLES synchronized cycles SHALL leave btn_clean unchanged, produce no pulse, and return the counter to 0.
REQ-017 Pin bounce during counting SHALL restart the count from 0 on every return to the current btn_clean value.
REQ-018 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL produce simultaneous pulses.
REQ-019 btn_press and btn_release of one channel SHALL never be high in the same cycle.
REQ-020 STABLE_CYCLES < 2 SHALL be rejected at elaboration.

Reset
REQ-021 While rst is high, s1, s2 and btn_clean SHALL be 1 (released), counters SHALL be 0, and btn_press and btn_release SHALL be 0.
REQ-022 Reset asserted mid-count SHALL discard the partial count; no pulse SHALL be emitted in the cycle after reset deassertion.
REQ-023 After reset deasserts with the pin held low, btn_press SHALL pulse once, STABLE_CYCLES+2 clocks later.

Structure
REQ-024 A shared package btn_pkg SHALL hold CLK_HZ = 27_000_000, DEBOUNCE_MS = 10 and the derived default STABLE_CYCLES.
REQ-025 Per-channel logic (synchronizer, counter, clean register, pulse registers) SHALL be one sub-module, btn_debounce_ch, instantiated NUM_BTN times by a generate loop.
REQ-026 btn_debounce SHALL contain no logic beyond the instantiation.

Verification (STABLE_CYCLES = 4)
REQ-027 Reset then hold btn = 2'b11 for 20 cycles -> btn_clean = 2'b11 throughout; no pulses.
REQ-028 Drive btn[0] 1->0 and hold -> btn_clean[0] falls exactly 6 clocks after the first sampling edge; btn_press[0] is high for exactly 1 cycle; btn_clean[1] is unchanged.
REQ-029 Pulse btn[0] low for 3 cycles, then high -> btn_clean[0] stays 1; no pulse.
REQ-030 Bounce pattern 0,1,0,0,1,0,0,0,0 on btn[1] -> a single btn_press[1], 6 clocks after the last 1->0 sample.
REQ-031 Both pins fall on the same edge, then both rise 20 cycles later -> press[1:0] = 2'b11 in one cycle; later release[1:0] = 2'b11 in one cycle.
REQ-032 Assert rst at count 2 of a pending press -> after release of rst, btn_clean = 1 and no pulse; btn_press follows REQ-023.
